// File: rtl/ref_row_streamer_if.sv
// Bundle of the block-request, reference-memory read and row-output signals
// between the row streamer (master) and its surroundings (slave).
interface ref_row_streamer_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_rdata;
    logic [119:0]      row_data;
    logic              row_valid;
    logic              row_ready;
    logic [3:0]        row_idx;
    logic              last_row;
    logic              busy;
    logic              done;

    modport master (
        input  start, abort, base_addr, mem_rdata, row_ready,
        output mem_rd_en, mem_addr, row_data, row_valid, row_idx, last_row, busy, done
    );

    modport slave (
        output start, abort, base_addr, mem_rdata, row_ready,
        input  mem_rd_en, mem_addr, row_data, row_valid, row_idx, last_row, busy, done
    );
endinterface

// File: rtl/ref_row_streamer.sv
// Streams a block of 120-bit reference rows, each assembled from two 64-bit
// memory words, to a valid/ready consumer.
module ref_row_streamer #(
    parameter int NUM_ROWS = 15,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    ref_row_streamer_if.master bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_LO   = 3'd1;
    localparam logic [2:0] RD_HI   = 3'd2;
    localparam logic [2:0] WAIT_HI = 3'd3;
    localparam logic [2:0] PRESENT = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic [3:0] LAST_ROW = 4'(NUM_ROWS - 1);

    logic [2:0]        state_reg;
    logic [2:0]        state_next;
    logic [ADDR_W-1:0] base_reg;
    logic [3:0]        row_reg;
    logic [119:0]      row_data_reg;
    logic              start_ok;
    logic              is_last;
    logic [ADDR_W-1:0] lo_addr;
    logic [ADDR_W-1:0] hi_addr;
    logic              unused_rdata_top;

    // Abort beats start in IDLE; elsewhere start is not looked at.
    assign start_ok = bus.start && !bus.abort;
    assign is_last  = (row_reg == LAST_ROW);

    // Row r occupies words base+2r and base+2r+1; sums wrap naturally.
    assign lo_addr = base_reg + ADDR_W'({row_reg, 1'b0});
    assign hi_addr = lo_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Pixel 15 slot does not exist, so the top byte of the high word is dropped.
    assign unused_rdata_top = &{1'b0, bus.mem_rdata[63:56]};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok) state_next = RD_LO;
            RD_LO:   state_next = RD_HI;
            RD_HI:   state_next = WAIT_HI;
            WAIT_HI: state_next = PRESENT;
            PRESENT: if (bus.row_ready) state_next = is_last ? DONE : RD_LO;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (state_reg != IDLE && bus.abort) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            base_reg     <= '0;
            row_reg      <= '0;
            row_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start_ok) begin
                base_reg <= bus.base_addr;
                row_reg  <= '0;
            end
            // An abort cancels any capture or row advance in flight.
            if (!bus.abort) begin
                if (state_reg == RD_HI)
                    row_data_reg[63:0] <= bus.mem_rdata;
                if (state_reg == WAIT_HI)
                    row_data_reg[119:64] <= bus.mem_rdata[55:0];
                if (state_reg == PRESENT && bus.row_ready && !is_last)
                    row_reg <= row_reg + 4'd1;
            end
        end
    end

    always_comb begin
        bus.mem_rd_en = 1'b0;
        bus.mem_addr  = '0;
        if (state_reg == RD_LO) begin
            bus.mem_rd_en = 1'b1;
            bus.mem_addr  = lo_addr;
        end else if (state_reg == RD_HI) begin
            bus.mem_rd_en = 1'b1;
            bus.mem_addr  = hi_addr;
        end
    end

    assign bus.row_data  = row_data_reg;
    assign bus.row_valid = (state_reg == PRESENT);
    assign bus.row_idx   = row_reg;
    assign bus.last_row  = (state_reg == PRESENT) && is_last;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = (state_reg == DONE);
endmodule
